// File: rtl/sequence_fifo.sv
// sequence_fifo: stores captured switch values and replays them on read.
// Define SEQUENCE_FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs.
module sequence_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  function automatic logic [ADDR_WIDTH-1:0] nxt(
    input logic [ADDR_WIDTH-1:0] p
  );
    return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign push  = write_enable & ~full & ~fifo_reset;
  assign pop   = read_enable & ~empty & ~fifo_reset;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (fifo_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= pop;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fifo_reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable & full) overflow  <= 1'b1;
      if (read_enable & empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sequence_fifo.sv
// tb_sequence_fifo: directed vector table plus corner-case sequences.
// Second instance with DEPTH=5 covers non-power-of-two wrap.
module tb_sequence_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_reset = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dv;
  logic       empty;
  logic       full;
  logic [3:0] count;

  logic       we5 = 1'b0;
  logic       re5 = 1'b0;
  logic [7:0] din5 = '0;
  logic [7:0] dout5;
  logic       dv5;
  logic       empty5;
  logic       full5;
  logic [3:0] count5;

`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
  logic ovf, unf, ovf5, unf5;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sequence_fifo #(.DATA_WIDTH(8), .DEPTH(8)) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .fifo_reset(fifo_reset),
    .write_enable(we),
    .read_enable(re),
    .din(din),
    .dout(dout),
    .dout_valid(dv),
    .empty(empty),
    .full(full),
`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
    .overflow(ovf),
    .underflow(unf),
`endif
    .count(count)
  );

  sequence_fifo #(.DATA_WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk),
    .reset_n(reset_n),
    .fifo_reset(1'b0),
    .write_enable(we5),
    .read_enable(re5),
    .din(din5),
    .dout(dout5),
    .dout_valid(dv5),
    .empty(empty5),
    .full(full5),
`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
    .overflow(ovf5),
    .underflow(unf5),
`endif
    .count(count5)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dv;
    logic [3:0] cnt;
    logic       e;
    logic       f;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic r,
                     input logic [7:0] d, input logic [7:0] o,
                     input logic v, input int c,
                     input logic e, input logic f);
    vec_t x;
    x.we = w; x.re = r; x.din = d; x.dout = o;
    x.dv = v; x.cnt = 4'(c); x.e = e; x.f = f;
    vecs.push_back(x);
  endtask

  task automatic step(input logic w, input logic r,
                      input logic [7:0] d);
    @(negedge clk);
    we = w; re = r; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step5(input logic w, input logic r,
                       input logic [7:0] d);
    @(negedge clk);
    we5 = w; re5 = r; din5 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 1; i <= 8; i++)
      add(1, 0, 8'(8'h11 * i), 8'h00, 0, i, 0, i == 8);
    add(1, 0, 8'hAA, 8'h00, 0, 8, 0, 1);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 8'h00, 8'(8'h11 * i), 1, 8 - i, i == 8, 0);
    add(0, 0, 8'h00, 8'h88, 0, 0, 1, 0);
    add(1, 0, 8'h01, 8'h88, 0, 1, 0, 0);
    add(1, 0, 8'h02, 8'h88, 0, 2, 0, 0);
    add(1, 1, 8'h03, 8'h01, 1, 2, 0, 0);
    for (int i = 4; i <= 9; i++)
      add(1, 0, 8'(i), 8'h01, 0, i - 1, 0, i == 9);
    add(1, 1, 8'hAB, 8'h02, 1, 7, 0, 0);
    for (int i = 3; i <= 9; i++)
      add(0, 1, 8'h00, 8'(i), 1, 9 - i, i == 9, 0);
    add(1, 1, 8'hCD, 8'h09, 0, 1, 0, 0);
    add(0, 1, 8'h00, 8'hCD, 1, 0, 1, 0);

    #12;
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst dout", 32'(dout), 0);
    chk("rst dv", 32'(dv), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h00);
      chk("erd dout", 32'(dout), 0);
      chk("erd dv", 32'(dv), 0);
      chk("erd count", 32'(count), 0);
    end
`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
    chk("underflow", 32'(unf), 1);
    chk("overflow clr", 32'(ovf), 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re, vecs[i].din);
      chk($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d dv", i), 32'(dv), 32'(vecs[i].dv));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e));
      chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].f));
    end
`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
    chk("overflow sticky", 32'(ovf), 1);
`endif

    for (int i = 1; i <= 5; i++) step(1, 0, 8'(8'h30 + i));
    step(0, 1, 8'h00);
    chk("frst pre dout", 32'(dout), 32'h31);
    chk("frst pre count", 32'(count), 4);
    @(negedge clk);
    fifo_reset = 1'b1; we = 1'b1; re = 1'b0; din = 8'hEE;
    @(posedge clk);
    #1;
    chk("frst count", 32'(count), 0);
    chk("frst empty", 32'(empty), 1);
    chk("frst dout", 32'(dout), 0);
    chk("frst dv", 32'(dv), 0);
`ifdef SEQUENCE_FIFO_ERR_FLAGS_EN
    chk("frst overflow", 32'(ovf), 0);
    chk("frst underflow", 32'(unf), 0);
`endif
    @(negedge clk);
    fifo_reset = 1'b0; we = 1'b0;
    step(0, 0, 8'h00);
    chk("frst hold count", 32'(count), 0);

    for (int i = 1; i <= 3; i++) step(1, 0, 8'(8'h40 + i));
    step(0, 1, 8'h00);
    step(1, 0, 8'h44);
    chk("arst pre count", 32'(count), 3);
    we = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst count", 32'(count), 0);
    chk("arst empty", 32'(empty), 1);
    chk("arst dout", 32'(dout), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 1; i <= 3; i++) step5(1, 0, 8'(8'hF0 + i));
    for (int i = 1; i <= 3; i++) begin
      step5(0, 1, 8'h00);
      chk("w5 pre dout", 32'(dout5), 32'(8'hF0 + i));
    end
    for (int i = 1; i <= 5; i++) begin
      step5(1, 0, 8'(i));
      chk("w5 count", 32'(count5), 32'(i));
      chk("w5 full", 32'(full5), 32'(i == 5));
    end
    for (int i = 1; i <= 5; i++) begin
      step5(0, 1, 8'h00);
      chk("w5 dout", 32'(dout5), 32'(i));
      chk("w5 dv", 32'(dv5), 1);
    end
    chk("w5 empty", 32'(empty5), 1);
    step5(0, 0, 8'h00);
    chk("w5 dv idle", 32'(dv5), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
